// File: rtl/distortion_processor.sv
// Scales a signed sample by gainNum/gainDen (multiply, 32-step restoring divide),
// hard-clips to +/-CLIP_LEVEL and emits one output sample with a valid strobe.
module distortion_processor #(
   parameter logic signed [15:0] CLIP_LEVEL = 16'sd8000,
   parameter int                 DROP_CNT_W = 8
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic signed [15:0]      sample_in,
   input  logic                    sample_valid,
   input  logic signed [15:0]      gainNum,
   input  logic signed [15:0]      gainDen,
   output logic signed [15:0]      sample_out,
   output logic                    out_valid,
   output logic                    busy,
   output logic [DROP_CNT_W-1:0]   drop_count
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, SAT} state_t;

   localparam logic signed [31:0] CLIP_HI = 32'(CLIP_LEVEL);
   localparam logic signed [31:0] CLIP_LO = -CLIP_HI;

   state_t               state_reg, state_next;
   logic [5:0]           iter_reg;
   logic signed [15:0]   sample_reg;
   logic [15:0]          num_reg, den_reg;
   logic                 sign_reg;
   logic [31:0]          quot_reg;
   logic [16:0]          rem_reg;

   logic signed [15:0]   gain_raw  [2];
   logic [15:0]          gain_safe [2];
   logic signed [31:0]   product;
   logic [31:0]          product_mag;
   logic [16:0]          rem_shift, rem_sub;
   logic                 rem_ge;
   logic signed [31:0]   quot_signed;
   logic signed [15:0]   clip_val;

   assign gain_raw[0] = gainNum;
   assign gain_raw[1] = gainDen;

   // Non-positive gain operands collapse to 1 so the divide always sees a positive divisor.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sanitise
         assign gain_safe[gi] = (gain_raw[gi] <= 16'sd0) ? 16'd1 : gain_raw[gi];
      end
   endgenerate

   assign product     = 32'(sample_reg) * 32'($signed(num_reg));
   assign product_mag = product[31] ? $unsigned(-product) : $unsigned(product);

   // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
   assign rem_shift = {rem_reg[15:0], quot_reg[31]};
   assign rem_ge    = rem_reg[16] | (rem_shift >= {1'b0, den_reg});
   assign rem_sub   = rem_shift - {1'b0, den_reg};

   assign quot_signed = sign_reg ? -$signed(quot_reg) : $signed(quot_reg);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (sample_valid) state_next = MUL;
         MUL:     state_next = DIV;
         DIV:     if (iter_reg == 6'd31) state_next = SAT;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg != IDLE);
      if (quot_signed > CLIP_HI)      clip_val = CLIP_LEVEL;
      else if (quot_signed < CLIP_LO) clip_val = -CLIP_LEVEL;
      else                            clip_val = quot_signed[15:0];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sample_reg <= '0;
         num_reg    <= '0;
         den_reg    <= '0;
         sign_reg   <= 1'b0;
         quot_reg   <= '0;
         rem_reg    <= '0;
         iter_reg   <= '0;
         sample_out <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state_reg)
            IDLE: if (sample_valid) begin
               sample_reg <= sample_in;
               num_reg    <= gain_safe[0];
               den_reg    <= gain_safe[1];
            end
            MUL: begin
               sign_reg <= product[31];
               quot_reg <= product_mag;
               rem_reg  <= '0;
               iter_reg <= '0;
            end
            DIV: begin
               rem_reg  <= rem_ge ? rem_sub : rem_shift;
               quot_reg <= {quot_reg[30:0], rem_ge};
               iter_reg <= iter_reg + 6'd1;
            end
            default: begin
               sample_out <= clip_val;
               out_valid  <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         drop_count <= '0;
      else if (busy && sample_valid && (drop_count != '1))
         drop_count <= drop_count + DROP_CNT_W'(1);
   end

endmodule

// File: tb/tb_distortion_processor.sv
// Randomised and directed bench for distortion_processor, checked every cycle
// against a latency/arithmetic model of the sample path.
module tb_distortion_processor;

   localparam int MAXD = 255;

   logic               CLK = 1'b0;
   logic               RST_N = 1'b0;
   logic signed [15:0] sample_in = '0;
   logic               sample_valid = 1'b0;
   logic signed [15:0] gainNum = '0;
   logic signed [15:0] gainDen = '0;
   logic signed [15:0] sample_out;
   logic               out_valid;
   logic               busy;
   logic [7:0]         drop_count;

   distortion_processor #(.CLIP_LEVEL(16'sd8000), .DROP_CNT_W(8)) dut (
      .CLK(CLK), .RST_N(RST_N), .sample_in(sample_in), .sample_valid(sample_valid),
      .gainNum(gainNum), .gainDen(gainDen), .sample_out(sample_out),
      .out_valid(out_valid), .busy(busy), .drop_count(drop_count)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected result from the arithmetic definition: sanitise, scale, truncate, clip.
   function automatic logic signed [15:0] model_out(input logic signed [15:0] s,
                                                    input logic signed [15:0] n,
                                                    input logic signed [15:0] d);
      longint nn, dd, q;
      nn = (n <= 0) ? 64'sd1 : longint'(n);
      dd = (d <= 0) ? 64'sd1 : longint'(d);
      q  = (longint'(s) * nn) / dd;
      if (q > 8000)  q = 8000;
      if (q < -8000) q = -8000;
      return 16'(q);
   endfunction

   // Model: an accepted sample produces its result 34 edges later; valid while busy is a drop.
   logic               m_busy, m_valid;
   int                 m_left, m_drop;
   logic signed [15:0] m_pend, m_out;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_busy <= 0; m_valid <= 0; m_left <= 0; m_drop <= 0; m_pend <= '0; m_out <= '0;
      end else begin
         m_valid <= 0;
         if (m_busy) begin
            if (sample_valid && m_drop != MAXD) m_drop <= m_drop + 1;
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_out <= m_pend; m_valid <= 1; m_busy <= 0;
            end
         end else if (sample_valid) begin
            m_pend <= model_out(sample_in, gainNum, gainDen);
            m_busy <= 1;
            m_left <= 34;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("out_valid",  int'(out_valid),  int'(m_valid));
         check("busy",       int'(busy),       int'(m_busy));
         check("drop_count", int'(drop_count), m_drop);
         check("sample_out", int'(sample_out), int'(m_out));
      end
   end

   function automatic logic signed [15:0] rand_gain();
      case ($urandom_range(0, 3))
         0:       return 16'($urandom_range(0, 8));
         1:       return -16'($urandom_range(0, 5));
         2:       return 16'($urandom);
         default: return 16'($urandom_range(1, 300));
      endcase
   endfunction

   task automatic do_reset(input int cycles);
      @(negedge CLK); #2 RST_N = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge CLK);
         sample_in = 16'($urandom); gainNum = 16'($urandom); gainDen = 16'($urandom);
         sample_valid = 1'($urandom);
      end
      sample_valid = 1'b0;
      #2 RST_N = 1'b1;
   endtask

   // Issue one sample, wait for its strobe, check latency and value against a literal.
   task automatic run_sample(input logic signed [15:0] s, input logic signed [15:0] n,
                             input logic signed [15:0] d, input logic signed [15:0] exp_val,
                             input int change_at, input logic signed [15:0] new_num);
      int lat;
      @(negedge CLK);
      sample_in = s; gainNum = n; gainDen = d; sample_valid = 1'b1;
      @(negedge CLK);
      sample_valid = 1'b0;
      sample_in = 16'($urandom); gainDen = rand_gain();
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         if (i - 1 == change_at) gainNum = new_num;
         @(negedge CLK);
         if (out_valid) begin lat = i; break; end
      end
      check("latency", lat, 34);
      check("result", int'(sample_out), int'(exp_val));
      @(negedge CLK);
      check("strobe_one_cycle", int'(out_valid), 0);
      check("busy_after", int'(busy), 0);
      $display("sample %0d * %0d / %0d -> %0d (latency %0d)", s, n, d, sample_out, lat);
   endtask

   initial begin
      int pulses;
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      // Pin the model to hand-computed results.
      check("model_3000",  int'(model_out(16'sd1000, 16'sd3, 16'sd1)), 3000);
      check("model_m10",   int'(model_out(-16'sd3, 16'sd7, 16'sd2)), -10);
      check("model_clipn", int'(model_out(-16'sd4000, 16'sd5, 16'sd2)), -8000);
      check("model_clipp", int'(model_out(16'sd32767, 16'sd50, 16'sd1)), 8000);
      check("model_den0",  int'(model_out(16'sd100, 16'sd2, 16'sd0)), 200);

      // 1: reset with random inputs
      @(posedge CLK);
      chk_en = 1'b1;
      do_reset(3);
      @(negedge CLK);
      check("rst_out",   int'(sample_out), 0);
      check("rst_valid", int'(out_valid),  0);
      check("rst_busy",  int'(busy),       0);
      check("rst_drop",  int'(drop_count), 0);
      $display("reset released, idle");

      // 2-4: directed samples
      run_sample(16'sd1000,   16'sd3,  16'sd1, 16'sd3000,  -1, 16'sd0);
      run_sample(-16'sd3,     16'sd7,  16'sd2, -16'sd10,   -1, 16'sd0);
      run_sample(-16'sd4000,  16'sd5,  16'sd2, -16'sd8000, -1, 16'sd0);
      run_sample(16'sd32767,  16'sd50, 16'sd1, 16'sd8000,  -1, 16'sd0);
      run_sample(16'sd100,    16'sd2,  16'sd0, 16'sd200,    4, 16'sd40);
      run_sample(16'sd1234,   16'sd1,  16'sd1, 16'sd1234,  -1, 16'sd0);

      // Random traffic, checked cycle by cycle by the model.
      for (int i = 0; i < 600; i++) begin
         @(negedge CLK);
         sample_valid = ($urandom_range(0, 5) == 0);
         sample_in = 16'($urandom);
         gainNum = rand_gain();
         gainDen = rand_gain();
         if (out_valid) $display("random result %0d", sample_out);
      end
      @(negedge CLK); sample_valid = 1'b0;
      repeat (40) @(negedge CLK);

      // 5: continuous valid for 100 edges from idle
      do_reset(2);
      pulses = 0;
      sample_in = 16'sd10; gainNum = 16'sd2; gainDen = 16'sd1;
      @(negedge CLK);
      sample_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (out_valid) pulses++;
      end
      sample_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (out_valid) pulses++;
      end
      check("burst_pulses", pulses, 3);
      check("burst_drops", int'(drop_count), 97);
      $display("burst: %0d pulses, drop_count %0d", pulses, drop_count);

      sample_valid = 1'b1;
      repeat (350) @(negedge CLK);
      sample_valid = 1'b0;
      repeat (40) @(negedge CLK);
      check("drop_sat", int'(drop_count), 255);
      $display("saturation: drop_count %0d", drop_count);

      // 6: reset mid-divide
      @(negedge CLK);
      sample_in = 16'sd321; gainNum = 16'sd3; gainDen = 16'sd1; sample_valid = 1'b1;
      @(negedge CLK);
      sample_valid = 1'b0;
      repeat (19) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      check("midrst_out",   int'(sample_out), 0);
      check("midrst_valid", int'(out_valid),  0);
      check("midrst_busy",  int'(busy),       0);
      check("midrst_drop",  int'(drop_count), 0);
      repeat (2) @(negedge CLK);
      #2 RST_N = 1'b1;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (out_valid) pulses++;
      end
      check("no_stale_valid", pulses, 0);
      $display("mid-divide reset: %0d stale strobes", pulses);
      run_sample(16'sd50, 16'sd2, 16'sd1, 16'sd100, -1, 16'sd0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
